// File: rtl/snd_pkg.sv
// Shared definitions for the 68k<->6502 sound-command mailbox.
package snd_pkg;

    // 68k register map (main_a)
    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS register layout as seen by the 68k
    typedef struct packed {
        logic [2:0] zero;
        logic       snd_rst_active;
        logic       rsp_ovf;
        logic       cmd_ovf;
        logic       cmd_full;
        logic       cmd_empty;
    } status_t;

endpackage

// File: rtl/snd_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB pointers; a pop and a push in the
// same cycle are both honoured, so a full FIFO accepts a push alongside a pop.
module snd_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             accepted,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign accepted = push && (!full || pop_ok) && !flush;
    assign head     = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write for accepted pushes
    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/snd_cmd_mailbox.sv
// 68k end of the sound-command link: command FIFO toward the 6502 with an NMI
// pulse per accepted command, a one-byte response latch raising main_irq, and
// the sound-board reset generator.
module snd_cmd_mailbox
    import snd_pkg::*;
#(
    parameter int unsigned CMD_DEPTH     = 4,
    parameter int unsigned NMI_CYCLES    = 8,
    parameter int unsigned SNDRST_CYCLES = 64
) (
    input  logic       clock_15,
    input  logic       rst_l,
    input  logic       main_cs_l,
    input  logic       main_rw,
    input  logic [1:0] main_a,
    input  logic [7:0] main_din,
    output logic [7:0] main_dout,
    output logic       main_irq,
    input  logic       RD68k_l,
    input  logic       WR68k_l,
    input  logic [7:0] snd_din,
    output logic [7:0] snd_dout,
    output logic       sndnmi,
    output logic       snd_rst_l
);

    localparam int unsigned NW = $clog2(NMI_CYCLES + 1);
    localparam int unsigned RW = $clog2(SNDRST_CYCLES + 1);

    logic          cs_q, rd_q, wr_q, rw_q;
    logic [1:0]    a_q;
    logic          cs_fall, cs_rise;
    logic          wr_cmd, wr_ctrl, rd_rsp_end, rd_stat_end;
    logic          snd_rd_end, snd_wr;
    logic          cmd_full, cmd_empty, push_acc;
    logic [7:0]    fifo_head;
    logic [NW-1:0] nmi_cnt;
    logic [RW-1:0] rst_cnt;
    logic [7:0]    rsp_data;
    logic          rsp_valid, rsp_ovf, cmd_ovf;
    status_t       status;

    // Single registration of every strobe; address/direction are kept so a
    // deassertion edge still knows which register the access targeted
    always_ff @(posedge clock_15 or negedge rst_l) begin
        if (!rst_l) begin
            cs_q <= 1'b1;
            rd_q <= 1'b1;
            wr_q <= 1'b1;
            rw_q <= 1'b1;
            a_q  <= '0;
        end else begin
            cs_q <= main_cs_l;
            rd_q <= RD68k_l;
            wr_q <= WR68k_l;
            rw_q <= main_rw;
            a_q  <= main_a;
        end
    end

    assign cs_fall     = cs_q && !main_cs_l;
    assign cs_rise     = !cs_q && main_cs_l;
    assign wr_cmd      = cs_fall && !main_rw && (main_a == REG_CMD);
    assign wr_ctrl     = cs_fall && !main_rw && (main_a == REG_CTRL) && main_din[0];
    assign rd_rsp_end  = cs_rise && rw_q && (a_q == REG_CMD);
    assign rd_stat_end = cs_rise && rw_q && (a_q == REG_STATUS);
    assign snd_rd_end  = !rd_q && RD68k_l && snd_rst_l;
    assign snd_wr      = wr_q && !WR68k_l && snd_rst_l;

    snd_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clock_15),
        .rst_n    (rst_l),
        .flush    (wr_ctrl),
        .push     (wr_cmd),
        .pop      (snd_rd_end),
        .din      (main_din),
        .head     (fifo_head),
        .accepted (push_acc),
        .full     (cmd_full),
        .empty    (cmd_empty)
    );

    // Sound-board reset hold: runs once after rst_l, restarts on each CTRL request
    always_ff @(posedge clock_15 or negedge rst_l) begin
        if (!rst_l)               rst_cnt <= RW'(SNDRST_CYCLES);
        else if (wr_ctrl)         rst_cnt <= RW'(SNDRST_CYCLES);
        else if (rst_cnt != '0)   rst_cnt <= rst_cnt - 1'b1;
    end

    // NMI pulse counter, reloaded by each accepted push
    always_ff @(posedge clock_15 or negedge rst_l) begin
        if (!rst_l)               nmi_cnt <= '0;
        else if (wr_ctrl)         nmi_cnt <= '0;
        else if (push_acc)        nmi_cnt <= NW'(NMI_CYCLES);
        else if (nmi_cnt != '0)   nmi_cnt <= nmi_cnt - 1'b1;
    end

    // Response latch and sticky overflow flags; sound reset beats everything,
    // a new event beats a same-cycle read-clear
    always_ff @(posedge clock_15 or negedge rst_l) begin
        if (!rst_l) begin
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_ovf   <= 1'b0;
            cmd_ovf   <= 1'b0;
        end else if (wr_ctrl) begin
            rsp_valid <= 1'b0;
            rsp_ovf   <= 1'b0;
            cmd_ovf   <= 1'b0;
        end else begin
            if (snd_wr) begin
                rsp_data  <= snd_din;
                rsp_valid <= 1'b1;
            end else if (rd_rsp_end) begin
                rsp_valid <= 1'b0;
            end

            if (snd_wr && rsp_valid) rsp_ovf <= 1'b1;
            else if (rd_stat_end)    rsp_ovf <= 1'b0;

            if (wr_cmd && !push_acc) cmd_ovf <= 1'b1;
            else if (rd_stat_end)    cmd_ovf <= 1'b0;
        end
    end

    // Interrupt toward the 68k follows rsp_valid by one cycle
    always_ff @(posedge clock_15 or negedge rst_l) begin
        if (!rst_l) main_irq <= 1'b0;
        else        main_irq <= rsp_valid;
    end

    assign status.zero           = '0;
    assign status.snd_rst_active = !snd_rst_l;
    assign status.rsp_ovf        = rsp_ovf;
    assign status.cmd_ovf        = cmd_ovf;
    assign status.cmd_full       = cmd_full;
    assign status.cmd_empty      = cmd_empty;

    // 68k read mux; unused addresses and idle bus read as zero
    always_comb begin
        main_dout = '0;
        if (!main_cs_l && main_rw) begin
            case (main_a)
                REG_CMD:    main_dout = rsp_data;
                REG_STATUS: main_dout = status;
                default:    main_dout = '0;
            endcase
        end
    end

    assign snd_dout  = cmd_empty ? 8'hFF : fifo_head;
    assign sndnmi    = (nmi_cnt != '0);
    assign snd_rst_l = (rst_cnt == '0);

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed bench for snd_cmd_mailbox with a command scoreboard queue.
module tb_snd_cmd_mailbox;

    logic       clock_15 = 1'b0;
    logic       rst_l    = 1'b0;
    logic       main_cs_l = 1'b1;
    logic       main_rw   = 1'b1;
    logic [1:0] main_a    = '0;
    logic [7:0] main_din  = '0;
    logic [7:0] main_dout;
    logic       main_irq;
    logic       RD68k_l = 1'b1;
    logic       WR68k_l = 1'b1;
    logic [7:0] snd_din = '0;
    logic [7:0] snd_dout;
    logic       sndnmi;
    logic       snd_rst_l;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  cmd_q[$];
    logic [7:0]  rd;
    int          n;

    always #5 clock_15 = ~clock_15;

    snd_cmd_mailbox #(
        .CMD_DEPTH     (4),
        .NMI_CYCLES    (8),
        .SNDRST_CYCLES (64)
    ) dut (
        .clock_15  (clock_15),
        .rst_l     (rst_l),
        .main_cs_l (main_cs_l),
        .main_rw   (main_rw),
        .main_a    (main_a),
        .main_din  (main_din),
        .main_dout (main_dout),
        .main_irq  (main_irq),
        .RD68k_l   (RD68k_l),
        .WR68k_l   (WR68k_l),
        .snd_din   (snd_din),
        .snd_dout  (snd_dout),
        .sndnmi    (sndnmi),
        .snd_rst_l (snd_rst_l)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock_15);
        main_cs_l = 1'b0; main_rw = 1'b0; main_a = a; main_din = d;
        repeat (4) @(negedge clock_15);
        main_cs_l = 1'b1;
        @(negedge clock_15);
    endtask

    task automatic m_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clock_15);
        main_cs_l = 1'b0; main_rw = 1'b1; main_a = a;
        repeat (2) @(negedge clock_15);
        #1 d = main_dout;
        @(negedge clock_15);
        main_cs_l = 1'b1;
        @(negedge clock_15);
    endtask

    // 6502 pop: the byte it reads is compared with the scoreboard head
    task automatic s_pop_check(input string tag);
        logic [7:0] exp;
        exp = (cmd_q.size() == 0) ? 8'hFF : cmd_q.pop_front();
        @(negedge clock_15);
        RD68k_l = 1'b0;
        @(negedge clock_15);
        #1 check(tag, {8'h00, snd_dout}, {8'h00, exp});
        @(negedge clock_15);
        RD68k_l = 1'b1;
        @(negedge clock_15);
    endtask

    task automatic s_write(input logic [7:0] d);
        @(negedge clock_15);
        snd_din = d; WR68k_l = 1'b0;
        repeat (2) @(negedge clock_15);
        WR68k_l = 1'b1;
        @(negedge clock_15);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. reset values and the one-shot sound reset hold
        repeat (3) @(negedge clock_15);
        #1;
        check("rst_main_dout", {8'h00, main_dout}, 16'h0000);
        check("rst_main_irq", {15'h0, main_irq}, 16'h0000);
        check("rst_snd_dout", {8'h00, snd_dout}, 16'h00FF);
        check("rst_sndnmi", {15'h0, sndnmi}, 16'h0000);
        check("rst_snd_rst_l", {15'h0, snd_rst_l}, 16'h0000);
        rst_l = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (snd_rst_l) break;
            n++;
            @(negedge clock_15);
            #1;
        end
        check("rst_hold_cycles", 16'(n), 16'd64);
        check("post_rst_nmi", {15'h0, sndnmi}, 16'h0000);
        m_read(2'd1, rd);
        check("post_rst_status", {8'h00, rd}, 16'h0001);

        // 2. single command, NMI width, pop, unused addresses
        @(negedge clock_15);
        main_cs_l = 1'b0; main_rw = 1'b0; main_a = 2'd0; main_din = 8'h3C;
        cmd_q.push_back(8'h3C);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_15);
            #1;
            if (i == 3) main_cs_l = 1'b1;
            if (sndnmi) n++;
        end
        check("nmi_width", 16'(n), 16'd8);
        check("head_3c", {8'h00, snd_dout}, 16'h003C);
        s_pop_check("pop_3c");
        #1 check("empty_ff", {8'h00, snd_dout}, 16'h00FF);
        m_read(2'd1, rd);
        check("status_after_pop", {8'h00, rd}, 16'h0001);
        m_read(2'd3, rd);
        check("read_a3", {8'h00, rd}, 16'h0000);
        m_read(2'd2, rd);
        check("read_ctrl", {8'h00, rd}, 16'h0000);
        m_write(2'd1, 8'hFF);
        m_read(2'd1, rd);
        check("status_after_wr_a1", {8'h00, rd}, 16'h0001);

        // 3. overflow of a depth-4 FIFO
        m_write(2'd0, 8'h11); cmd_q.push_back(8'h11);
        m_write(2'd0, 8'h22); cmd_q.push_back(8'h22);
        m_write(2'd0, 8'h33); cmd_q.push_back(8'h33);
        m_write(2'd0, 8'h44); cmd_q.push_back(8'h44);
        m_write(2'd0, 8'h55);
        m_read(2'd1, rd);
        check("status_ovf", {8'h00, rd}, 16'h0006);
        s_pop_check("pop_11");
        s_pop_check("pop_22");
        s_pop_check("pop_33");
        s_pop_check("pop_44");
        s_pop_check("pop_empty");
        m_read(2'd1, rd);
        check("status_ovf_cleared", {8'h00, rd}, 16'h0001);

        // 4. response latch, overwrite, irq latency
        @(negedge clock_15);
        snd_din = 8'hA5; WR68k_l = 1'b0;
        @(negedge clock_15);
        #1 check("irq_latency0", {15'h0, main_irq}, 16'h0000);
        @(negedge clock_15);
        #1 check("irq_latency1", {15'h0, main_irq}, 16'h0001);
        WR68k_l = 1'b1;
        @(negedge clock_15);
        s_write(8'h5A);
        #1 check("irq_after_5a", {15'h0, main_irq}, 16'h0001);
        m_read(2'd0, rd);
        check("rsp_5a", {8'h00, rd}, 16'h005A);
        @(negedge clock_15);
        #1 check("irq_cleared", {15'h0, main_irq}, 16'h0000);
        m_read(2'd1, rd);
        check("status_rsp_ovf", {8'h00, rd}, 16'h0009);
        m_read(2'd1, rd);
        check("status_rsp_ovf_clr", {8'h00, rd}, 16'h0001);

        // 5a. push on a full FIFO in the same cycle as a pop
        m_write(2'd0, 8'hA1); cmd_q.push_back(8'hA1);
        m_write(2'd0, 8'hA2); cmd_q.push_back(8'hA2);
        m_write(2'd0, 8'hA3); cmd_q.push_back(8'hA3);
        m_write(2'd0, 8'hA4); cmd_q.push_back(8'hA4);
        @(negedge clock_15);
        RD68k_l = 1'b0;
        @(negedge clock_15);
        #1 check("pp_head", {8'h00, snd_dout}, {8'h00, cmd_q[0]});
        @(negedge clock_15);
        main_cs_l = 1'b0; main_rw = 1'b0; main_a = 2'd0; main_din = 8'hB5;
        RD68k_l = 1'b1;
        rd = cmd_q.pop_front();
        cmd_q.push_back(8'hB5);
        repeat (3) @(negedge clock_15);
        main_cs_l = 1'b1;
        @(negedge clock_15);
        m_read(2'd1, rd);
        check("pp_status_full", {8'h00, rd}, 16'h0002);
        s_pop_check("pp_pop_a2");
        s_pop_check("pp_pop_a3");
        s_pop_check("pp_pop_a4");
        s_pop_check("pp_pop_b5");
        #1 check("pp_empty", {8'h00, snd_dout}, 16'h00FF);

        // 5b. response write coinciding with the end of a 68k response read
        s_write(8'h77);
        @(negedge clock_15);
        main_cs_l = 1'b0; main_rw = 1'b1; main_a = 2'd0;
        repeat (2) @(negedge clock_15);
        #1 check("rsp_77", {8'h00, main_dout}, 16'h0077);
        @(negedge clock_15);
        main_cs_l = 1'b1; snd_din = 8'h88; WR68k_l = 1'b0;
        repeat (2) @(negedge clock_15);
        #1 check("race_irq_kept", {15'h0, main_irq}, 16'h0001);
        WR68k_l = 1'b1;
        @(negedge clock_15);
        m_read(2'd0, rd);
        check("race_rsp_88", {8'h00, rd}, 16'h0088);
        m_read(2'd1, rd);
        check("race_status", {8'h00, rd}, 16'h0009);

        // 6. sound reset with queued commands and an active NMI
        m_write(2'd0, 8'hC1); cmd_q.push_back(8'hC1);
        m_write(2'd0, 8'hC2); cmd_q.push_back(8'hC2);
        m_write(2'd0, 8'hC3); cmd_q.push_back(8'hC3);
        #1 check("nmi_before_ctrl", {15'h0, sndnmi}, 16'h0001);
        @(negedge clock_15);
        main_cs_l = 1'b0; main_rw = 1'b0; main_a = 2'd2; main_din = 8'h01;
        cmd_q.delete();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock_15);
            #1;
            if (i == 0) begin
                check("ctrl_nmi_off", {15'h0, sndnmi}, 16'h0000);
                check("ctrl_flushed", {8'h00, snd_dout}, 16'h00FF);
            end
            if (i == 3)  main_cs_l = 1'b1;
            if (i == 5)  RD68k_l = 1'b0;
            if (i == 8)  RD68k_l = 1'b1;
            if (i == 10) begin snd_din = 8'h99; WR68k_l = 1'b0; end
            if (i == 13) WR68k_l = 1'b1;
            if (snd_rst_l) break;
            n++;
        end
        check("ctrl_hold_cycles", 16'(n), 16'd64);
        @(negedge clock_15);
        #1 check("ctrl_irq_ignored", {15'h0, main_irq}, 16'h0000);
        m_read(2'd1, rd);
        check("ctrl_status", {8'h00, rd}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
